// File: rtl/picorv32_pcpi_galois.sv
// PCPI co-processor for carry-less and GF(2^8) arithmetic.
// Custom-0 opcode, funct7 = 0, funct3 selects CLMUL, CLMULH, GF8MUL or GFADD.
// Default build iterates one multiplier bit per cycle; defining
// PCPI_GALOIS_FAST_EN computes every operation in the claim cycle instead.
module picorv32_pcpi_galois #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pcpi_valid,
  input  logic [31:0]           pcpi_insn,
  input  logic [DATA_WIDTH-1:0] pcpi_rs1,
  input  logic [DATA_WIDTH-1:0] pcpi_rs2,
  output logic                  pcpi_wr,
  output logic [DATA_WIDTH-1:0] pcpi_rd,
  output logic                  pcpi_wait,
  output logic                  pcpi_ready
);

  localparam int AccW  = 2 * DATA_WIDTH;
  localparam int Lanes = DATA_WIDTH / 8;

  localparam logic [1:0] OpClmul  = 2'd0;
  localparam logic [1:0] OpClmulh = 2'd1;
  localparam logic [1:0] OpGf8    = 2'd2;
  localparam logic [1:0] OpGfadd  = 2'd3;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q;
  logic [1:0]            funct_q;
  logic [AccW-1:0]       acc_q, acc_step;
  logic [DATA_WIDTH-1:0] result_step;
  logic [4:0]            cnt_q;
  logic                  insn_match, claim;
  logic                  unused_insn_bits;

  // Multiply-by-x in GF(2^8) with the AES polynomial 0x11B.
  function automatic logic [7:0] gf_xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

`ifdef PCPI_GALOIS_FAST_EN
  // Full 2*W-bit carry-less product.
  function automatic logic [AccW-1:0] clmul_full(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic [AccW-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (b[i]) p = p ^ ({{DATA_WIDTH{1'b0}}, a} << i);
    end
    return p;
  endfunction

  // Independent GF(2^8) product in every byte lane.
  function automatic logic [DATA_WIDTH-1:0] gf8_lanes(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] out;
    logic [7:0]            r;
    out = '0;
    for (int l = 0; l < Lanes; l++) begin
      r = 8'h00;
      for (int k = 7; k >= 0; k--) begin
        r = gf_xtime(r) ^ (b[8*l+k] ? a[8*l +: 8] : 8'h00);
      end
      out[8*l +: 8] = r;
    end
    return out;
  endfunction

  // Single-cycle result for any claimed operation.
  function automatic logic [DATA_WIDTH-1:0] fast_result(input logic [1:0]            op,
                                                        input logic [DATA_WIDTH-1:0] a,
                                                        input logic [DATA_WIDTH-1:0] b);
    logic [AccW-1:0]       prod;
    logic [DATA_WIDTH-1:0] r;
    prod = clmul_full(a, b);
    case (op)
      OpClmul:  r = prod[DATA_WIDTH-1:0];
      OpClmulh: r = prod[AccW-1:DATA_WIDTH];
      OpGf8:    r = gf8_lanes(a, b);
      default:  r = a ^ b;
    endcase
    return r;
  endfunction
`endif

  // Only custom-0, funct7 = 0, funct3 = 0xx is ours; rd/rs fields are the core's business.
  assign insn_match = (pcpi_insn[6:0] == 7'b0001011) &&
                      (pcpi_insn[31:25] == 7'b0000000) &&
                      !pcpi_insn[14];
  assign claim      = pcpi_valid && insn_match && (state_q == IDLE);
  assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // One multiplier bit per step, MSB first: shift the accumulator, then add the operand.
  always_comb begin
    acc_step = {acc_q[AccW-2:0], 1'b0} ^
               (op_b_q[DATA_WIDTH-1] ? {{DATA_WIDTH{1'b0}}, op_a_q} : '0);
    if (funct_q == OpGf8) begin
      acc_step = '0;
      for (int l = 0; l < Lanes; l++) begin
        acc_step[8*l +: 8] = gf_xtime(acc_q[8*l +: 8]) ^
                             (op_b_q[8*l+7] ? op_a_q[8*l +: 8] : 8'h00);
      end
    end
    result_step = (funct_q == OpClmulh) ? acc_step[AccW-1:DATA_WIDTH]
                                        : acc_step[DATA_WIDTH-1:0];
  end

  // Next-state logic; a dropped pcpi_valid while busy abandons the operation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (claim) begin
`ifdef PCPI_GALOIS_FAST_EN
          state_d = DONE;
`else
          state_d = (pcpi_insn[13:12] == OpGfadd) ? DONE : BUSY;
`endif
        end
      end
      BUSY: begin
        if (!pcpi_valid)        state_d = IDLE;
        else if (cnt_q == 5'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operand latch, iteration datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      funct_q    <= 2'd0;
      acc_q      <= '0;
      cnt_q      <= 5'd0;
      pcpi_rd    <= '0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
    end else begin
      pcpi_wait  <= (state_d == BUSY);
      pcpi_ready <= (state_d == DONE);
      pcpi_wr    <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (claim) begin
            op_a_q  <= pcpi_rs1;
            op_b_q  <= pcpi_rs2;
            funct_q <= pcpi_insn[13:12];
            acc_q   <= '0;
            cnt_q   <= (pcpi_insn[13:12] == OpGf8) ? 5'd7 : 5'd31;
`ifdef PCPI_GALOIS_FAST_EN
            pcpi_rd <= fast_result(pcpi_insn[13:12], pcpi_rs1, pcpi_rs2);
`else
            if (pcpi_insn[13:12] == OpGfadd) pcpi_rd <= pcpi_rs1 ^ pcpi_rs2;
`endif
          end
        end
        BUSY: begin
          if (pcpi_valid) begin
            acc_q  <= acc_step;
            op_b_q <= op_b_q << 1;
            cnt_q  <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) pcpi_rd <= result_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_pcpi_galois.sv
// Bench for picorv32_pcpi_galois: directed literal cases plus randomized
// traffic, all outputs compared every cycle against a transaction-level model.
module tb_picorv32_pcpi_galois;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = 32'h0;
  logic [31:0] pcpi_rs1 = 32'h0;
  logic [31:0] pcpi_rs2 = 32'h0;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;

`ifdef PCPI_GALOIS_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  always #5 clk = ~clk;

  picorv32_pcpi_galois #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          pin_en  = 1'b0;
  logic [31:0] pin_rd  = 32'h0;

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_clmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'h0;
    for (int i = 0; i < 32; i++) if (a[i]) p = p ^ ({32'h0, b} << i);
    return p;
  endfunction

  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic       hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1B;
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] m_result(input logic [1:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = m_clmul(a, b);
    case (f)
      2'd0: r = p[31:0];
      2'd1: r = p[63:32];
      2'd2: for (int l = 0; l < 4; l++) r[8*l +: 8] = m_gmul(a[8*l +: 8], b[8*l +: 8]);
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  function automatic bit m_legal(input logic [31:0] insn);
    return (insn[6:0] == 7'b0001011) && (insn[31:25] == 7'h00) && (insn[14:12] < 3'd4);
  endfunction

  function automatic int lat_of(input logic [1:0] f);
    if (FAST)       return 1;
    if (f == 2'd3)  return 1;
    if (f == 2'd2)  return 9;
    return 33;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model advances on each edge from the sampled inputs; outputs compared 3 time units later.
  initial begin
    bit          m_active;
    int          m_age, m_lat;
    logic [31:0] m_res, m_last_rd;
    bit          can_claim;
    logic        exp_wait, exp_ready;
    m_active = 0; m_age = 0; m_lat = 1; m_res = 0; m_last_rd = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_active = 0;
        m_last_rd = 0;
      end else begin
        can_claim = !m_active;
        if (m_active) begin
          m_age++;
          if (m_age <= m_lat - 1 && !pcpi_valid) m_active = 0;
          else if (m_age >= m_lat)               m_active = 0;
        end
        if (can_claim && pcpi_valid && m_legal(pcpi_insn)) begin
          m_active = 1;
          m_age    = 0;
          m_lat    = lat_of(pcpi_insn[13:12]);
          m_res    = m_result(pcpi_insn[13:12], pcpi_rs1, pcpi_rs2);
        end
      end
      #3;
      if (reset) begin
        m_active  = 0;
        m_last_rd = 0;
        exp_wait  = 0;
        exp_ready = 0;
      end else begin
        exp_wait  = m_active && (m_age <= m_lat - 2);
        exp_ready = m_active && (m_age == m_lat - 1);
        if (exp_ready) m_last_rd = m_res;
      end
      chk("wait",  {31'h0, pcpi_wait},  {31'h0, exp_wait});
      chk("ready", {31'h0, pcpi_ready}, {31'h0, exp_ready});
      chk("wr",    {31'h0, pcpi_wr},    {31'h0, exp_ready});
      chk("rd",    pcpi_rd, m_last_rd);
      if (exp_ready && pin_en) begin
        chk("pin_dut_rd", pcpi_rd, pin_rd);
        chk("pin_model",  m_res,   pin_rd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [6:0] opc);
    logic [31:0] r;
    r = $urandom;
    r[31:25] = f7;
    r[14:12] = f3;
    r[6:0]   = opc;
    return r;
  endfunction

  task automatic run_op(input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, input int abort_at);
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    pcpi_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (pcpi_ready) begin
        pcpi_valid = 1'b0;
        return;
      end
      if (k == abort_at) begin
        pcpi_valid = 1'b0;
        tick();
        return;
      end
    end
    $display("FAIL timeout: no ready for insn %h", insn);
    $fatal(1);
  endtask

  task automatic run_pinned(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
    pin_en = 1'b1;
    pin_rd = exp;
    run_op(mk(7'h00, f3, 7'b0001011), a, b, -1);
    tick();
    pin_en = 1'b0;
  endtask

  task automatic run_ignored(input logic [31:0] insn);
    pcpi_insn  = insn;
    pcpi_rs1   = $urandom;
    pcpi_rs2   = $urandom;
    pcpi_valid = 1'b1;
    repeat (3) tick();
    pcpi_valid = 1'b0;
    tick();
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          ab;
    #1 reset = 1'b1;
    repeat (3) tick();
    #1 reset = 1'b0;
    tick();

    // Literal cases
    run_pinned(3'd0, 32'h00000003, 32'h00000003, 32'h00000005);
    run_pinned(3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
    run_pinned(3'd0, 32'h80000000, 32'h80000000, 32'h00000000);
    run_pinned(3'd2, 32'h57575757, 32'h83831313, 32'hC1C1FEFE);
    run_pinned(3'd3, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F);
    run_pinned(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555);

    // Encodings that must be ignored
    run_ignored(mk(7'b0000001, 3'd0, 7'b0001011));
    run_ignored(mk(7'h00, 3'd0, 7'b0110011));
    run_ignored(mk(7'h00, 3'd5, 7'b0001011));

    // Abort by dropping pcpi_valid mid-operation
    run_op(mk(7'h00, 3'd0, 7'b0001011), 32'h12345678, 32'h9ABCDEF0, 9);
    run_op(mk(7'h00, 3'd2, 7'b0001011), 32'hA5A5A5A5, 32'h3C3C3C3C, 3);

    // Reset mid-operation, then a clean CLMUL
    pcpi_insn  = mk(7'h00, 3'd0, 7'b0001011);
    pcpi_rs1   = 32'hDEADBEEF;
    pcpi_rs2   = 32'hCAFEF00D;
    pcpi_valid = 1'b1;
    repeat (5) tick();
    #1;
    reset      = 1'b1;
    pcpi_valid = 1'b0;
    tick();
    #1 reset = 1'b0;
    tick();
    run_pinned(3'd0, 32'h00000003, 32'h00000003, 32'h00000005);

    // Randomized traffic, including back-to-back issue and random aborts
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFF;
      if ($urandom_range(0, 7) == 0) b = 32'h00000000;
      if ($urandom_range(0, 9) == 0) begin
        f3 = 3'($urandom_range(4, 7));
        run_ignored(mk(($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20, f3, 7'b0001011));
      end else begin
        f3 = 3'($urandom_range(0, 3));
        ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : -1;
        run_op(mk(7'h00, f3, 7'b0001011), a, b, ab);
      end
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
